nn_layer_scheduler: RTL
=======================

NN_LAYER_SCHEDULER -- requirements
Module: nn_layer_scheduler

Interface
REQ-001 SHALL have parameter LENGHT_I, default 32, meaning input-layer neuron count.
REQ-002 SHALL have parameter LENGHT_MID, default 8, meaning mid-layer neuron count.
REQ-003 SHALL have parameter LENGHT_O, default 2, meaning output-layer neuron count.
REQ-004 SHALL have parameter WIDTH_ADDR, default $clog2(LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O) (9), meaning weight-address width.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request one forward pass; sampled only in IDLE.
REQ-008 abort  in  1  synchronous cancel of the pass in progress.
REQ-009 busy  out  1  pass in progress.
REQ-010 done  out  1  one-cycle pulse on pass completion.
REQ-011 w_rd  out  1  weight-memory read strobe; data valid next cycle.
REQ-012 w_addr  out  WIDTH_ADDR  weight address.
REQ-013 src_sel  out  1  operand source: 0 input vector, 1 mid activations.
REQ-014 src_idx  out  $clog2(LENGHT_I)  operand index, aligned with w_rd.
REQ-015 mac_clr  out  1  accumulator load-instead-of-add, aligned with mac_en.
REQ-016 mac_en  out  1  accumulate current product.
REQ-017 act_wr  out  1  write activation of the finished neuron.
REQ-018 act_layer  out  1  0 mid layer, 1 output layer.
REQ-019 act_idx  out  $clog2(LENGHT_MID)  neuron index being written.

Function
REQ-020 All outputs SHALL be registered.
REQ-021 States SHALL be IDLE, MID, MID_DRAIN, OUT, OUT_DRAIN, DONE.
REQ-022 IDLE->MID when start=1 and abort=0; abort has priority over start.
REQ-023 MID: one w_rd per cycle, back-to-back, neuron n outer, term i inner, w_addr=n*LENGHT_I+i, src_sel=0, src_idx=i; LENGHT_I*LENGHT_MID issues, then MID_DRAIN.
REQ-024 OUT: w_addr=LENGHT_I*LENGHT_MID+o*LENGHT_MID+m, src_sel=1, src_idx=m; LENGHT_MID*LENGHT_O issues, then OUT_DRAIN.
REQ-025 mac_en SHALL equal w_rd delayed 1 cycle; mac_clr high with the mac_en of term 0 of each neuron.
REQ-026 act_wr SHALL pulse 2 cycles after the last-term w_rd of each neuron, with act_layer/act_idx of that neuron.
REQ-027 MID_DRAIN and OUT_DRAIN SHALL last exactly 2 cycles, so every mid act_wr precedes the first OUT w_rd.
REQ-028 DONE lasts 1 cycle: done=1, busy=0; then IDLE. start in DONE ignored.
REQ-029 busy=1 in MID, MID_DRAIN, OUT, OUT_DRAIN only.
REQ-030 Defaults (start accepted cycle 0): w_rd cycles 1-256, mid act_wr 34+32n (last 258), OUT w_rd 259-274, out act_wr 268 and 276, done 277, IDLE 278.
REQ-031 abort=1 in any non-IDLE state: next cycle IDLE, all outputs 0; pending mac_en/act_wr in the pipeline suppressed; no done.
REQ-032 Counters SHALL wrap to 0 at each neuron/layer boundary; no out-of-range w_addr ever issued.

Reset
REQ-033 reset_n=0 SHALL asynchronously force IDLE, counters 0, every output 0, pipeline strobes cleared.
REQ-034 Reset mid-pass SHALL abandon the pass; first post-reset action requires a new start.

Structure
REQ-035 Package nn_pkg SHALL hold LENGHT_I/MID/O, OUT_W_BASE (LENGHT_I*LENGHT_MID), and the state enum typedef.
REQ-036 One sub-module nn_term_counter (nested neuron/term counter with first/last flags) SHALL be instantiated once per layer walk or shared.

Verification
REQ-037 Reset then start pulse at cycle 0 -> w_addr 0..255 cycles 1-256, 256..271 cycles 259-274, done only at 277.
REQ-038 Mid neuron 3 -> mac_clr at cycle 98, act_wr at 130 with act_layer=0, act_idx=3.
REQ-039 abort at cycle 100 -> cycle 101 all outputs 0, state IDLE, no act_wr for neuron 3, no done.
REQ-040 start held high through a pass -> exactly one pass, start in DONE ignored, next pass begins cycle 279.
REQ-041 reset_n low at cycle 260 -> outputs 0 immediately (asynchronous), no done; new start runs a full clean pass.
REQ-042 start and abort both high in IDLE -> remains IDLE, busy=0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and FSM state type for the
// two-layer neural-network weight scheduler.
package nn_pkg;

  localparam int LENGHT_I   = 32;
  localparam int LENGHT_MID = 8;
  localparam int LENGHT_O   = 2;
  localparam int OUT_W_BASE = LENGHT_I * LENGHT_MID;

  typedef enum logic [2:0] {
    IDLE,
    MID,
    MID_DRAIN,
    OUT,
    OUT_DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/nn_layer_scheduler_counter.sv
// Nested neuron/term counter shared by both layer walks;
// wrap_q flags that the final term of the final neuron was issued.
module nn_term_counter #(
  parameter int NW = 3,
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          step,
  input  logic [NW-1:0] nrn_max,
  input  logic [TW-1:0] trm_max,
  output logic [NW-1:0] nrn_q,
  output logic [TW-1:0] trm_q,
  output logic          first,
  output logic          last,
  output logic          wrap_q
);

  logic [NW-1:0] nrn_d;
  logic [TW-1:0] trm_d;
  logic          wrap_d;

  assign first = (trm_q == '0);
  assign last  = (trm_q == trm_max);

  always_comb begin
    nrn_d  = nrn_q;
    trm_d  = trm_q;
    wrap_d = wrap_q;
    if (clr) begin
      nrn_d  = '0;
      trm_d  = '0;
      wrap_d = 1'b0;
    end else if (step) begin
      wrap_d = 1'b0;
      if (!last) begin
        trm_d = trm_q + TW'(1);
      end else begin
        trm_d = '0;
        if (nrn_q == nrn_max) begin
          nrn_d  = '0;
          wrap_d = 1'b1;
        end else begin
          nrn_d = nrn_q + NW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nrn_q  <= '0;
      trm_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      nrn_q  <= nrn_d;
      trm_q  <= trm_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: rtl/nn_layer_scheduler.sv
// Forward-pass scheduler: walks mid then output layer weights,
// driving weight reads, MAC strobes and activation writes.
module nn_layer_scheduler #(
  parameter int LENGHT_I   = nn_pkg::LENGHT_I,
  parameter int LENGHT_MID = nn_pkg::LENGHT_MID,
  parameter int LENGHT_O   = nn_pkg::LENGHT_O,
  parameter int WIDTH_ADDR =
    $clog2(LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          w_rd,
  output logic [WIDTH_ADDR-1:0]         w_addr,
  output logic                          src_sel,
  output logic [$clog2(LENGHT_I)-1:0]   src_idx,
  output logic                          mac_clr,
  output logic                          mac_en,
  output logic                          act_wr,
  output logic                          act_layer,
  output logic [$clog2(LENGHT_MID)-1:0] act_idx
);

  import nn_pkg::state_e;
  import nn_pkg::IDLE;
  import nn_pkg::MID;
  import nn_pkg::MID_DRAIN;
  import nn_pkg::OUT;
  import nn_pkg::OUT_DRAIN;
  import nn_pkg::DONE;

  localparam int SW     = $clog2(LENGHT_I);
  localparam int NW     = $clog2(LENGHT_MID);
  localparam int W_BASE = LENGHT_I * LENGHT_MID;

  state_e state_q, state_d;
  logic   drn_q, drn_d;
  logic   iss, cnt_clr, cnt_step, layer;

  logic [NW-1:0] c_nrn;
  logic [SW-1:0] c_trm;
  logic          c_first, c_last, c_wrap;
  logic [NW-1:0] nrn_max;
  logic [SW-1:0] trm_max;

  logic                  w_rd_q, w_rd_d;
  logic [WIDTH_ADDR-1:0] w_addr_q, w_addr_d;
  logic                  src_sel_q, src_sel_d;
  logic [SW-1:0]         src_idx_q, src_idx_d;
  logic                  tf_q, tf_d, tl_q, tl_d;
  logic [NW-1:0]         tn_q, tn_d;
  logic                  mac_en_q, mac_en_d;
  logic                  mac_clr_q, mac_clr_d;
  logic                  pw_q, pw_d, pl_q, pl_d;
  logic [NW-1:0]         pn_q, pn_d;
  logic                  act_wr_q, act_wr_d;
  logic                  act_layer_q, act_layer_d;
  logic [NW-1:0]         act_idx_q, act_idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  assign layer   = (state_q == MID_DRAIN) || (state_q == OUT);
  assign nrn_max = layer ? NW'(LENGHT_O-1) : NW'(LENGHT_MID-1);
  assign trm_max = layer ? SW'(LENGHT_MID-1) : SW'(LENGHT_I-1);

  nn_term_counter #(
    .NW(NW),
    .TW(SW)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .step   (cnt_step),
    .nrn_max(nrn_max),
    .trm_max(trm_max),
    .nrn_q  (c_nrn),
    .trm_q  (c_trm),
    .first  (c_first),
    .last   (c_last),
    .wrap_q (c_wrap)
  );

  // Issue decisions are made one cycle ahead so outputs come from flops.
  always_comb begin
    state_d  = state_q;
    drn_d    = 1'b0;
    iss      = 1'b0;
    cnt_clr  = 1'b0;
    cnt_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = MID;
          iss      = 1'b1;
          cnt_step = 1'b1;
        end
      end
      MID, OUT: begin
        if (c_wrap) begin
          state_d = (state_q == MID) ? MID_DRAIN : OUT_DRAIN;
          cnt_clr = 1'b1;
        end else begin
          iss      = 1'b1;
          cnt_step = 1'b1;
        end
      end
      MID_DRAIN: begin
        if (drn_q) begin
          state_d  = OUT;
          iss      = 1'b1;
          cnt_step = 1'b1;
        end else begin
          drn_d = 1'b1;
        end
      end
      OUT_DRAIN: begin
        if (drn_q) state_d = DONE;
        else       drn_d   = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      drn_d    = 1'b0;
      iss      = 1'b0;
      cnt_clr  = 1'b1;
      cnt_step = 1'b0;
    end
  end

  always_comb begin
    w_rd_d    = iss;
    w_addr_d  = '0;
    src_sel_d = 1'b0;
    src_idx_d = '0;
    tf_d      = 1'b0;
    tl_d      = 1'b0;
    tn_d      = '0;
    if (iss) begin
      src_sel_d = layer;
      src_idx_d = c_trm;
      tf_d      = c_first;
      tl_d      = c_last;
      tn_d      = c_nrn;
      if (layer)
        w_addr_d = WIDTH_ADDR'(W_BASE)
                 + WIDTH_ADDR'(c_nrn) * WIDTH_ADDR'(LENGHT_MID)
                 + WIDTH_ADDR'(c_trm);
      else
        w_addr_d = WIDTH_ADDR'(c_nrn) * WIDTH_ADDR'(LENGHT_I)
                 + WIDTH_ADDR'(c_trm);
    end
    mac_en_d    = w_rd_q;
    mac_clr_d   = w_rd_q & tf_q;
    pw_d        = w_rd_q & tl_q;
    pl_d        = pw_d & src_sel_q;
    pn_d        = pw_d ? tn_q : '0;
    act_wr_d    = pw_q;
    act_layer_d = pl_q;
    act_idx_d   = pn_q;
    busy_d      = (state_d == MID) || (state_d == MID_DRAIN)
               || (state_d == OUT) || (state_d == OUT_DRAIN);
    done_d      = (state_d == DONE);
    if (abort) begin
      mac_en_d    = 1'b0;
      mac_clr_d   = 1'b0;
      pw_d        = 1'b0;
      pl_d        = 1'b0;
      pn_d        = '0;
      act_wr_d    = 1'b0;
      act_layer_d = 1'b0;
      act_idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      drn_q       <= 1'b0;
      w_rd_q      <= 1'b0;
      w_addr_q    <= '0;
      src_sel_q   <= 1'b0;
      src_idx_q   <= '0;
      tf_q        <= 1'b0;
      tl_q        <= 1'b0;
      tn_q        <= '0;
      mac_en_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
      pw_q        <= 1'b0;
      pl_q        <= 1'b0;
      pn_q        <= '0;
      act_wr_q    <= 1'b0;
      act_layer_q <= 1'b0;
      act_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drn_q       <= drn_d;
      w_rd_q      <= w_rd_d;
      w_addr_q    <= w_addr_d;
      src_sel_q   <= src_sel_d;
      src_idx_q   <= src_idx_d;
      tf_q        <= tf_d;
      tl_q        <= tl_d;
      tn_q        <= tn_d;
      mac_en_q    <= mac_en_d;
      mac_clr_q   <= mac_clr_d;
      pw_q        <= pw_d;
      pl_q        <= pl_d;
      pn_q        <= pn_d;
      act_wr_q    <= act_wr_d;
      act_layer_q <= act_layer_d;
      act_idx_q   <= act_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign w_rd      = w_rd_q;
  assign w_addr    = w_addr_q;
  assign src_sel   = src_sel_q;
  assign src_idx   = src_idx_q;
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign act_wr    = act_wr_q;
  assign act_layer = act_layer_q;
  assign act_idx   = act_idx_q;

endmodule
